// File: rtl/bomb_dropper.sv
// Falling-bomb position generator: WAIT -> FALL -> EXPLODE loop, one step per frame.
// Define BOMB_SPEEDUP_EN to raise the fall step by one after every 8th landing.
module bomb_dropper #(
  parameter logic [9:0]  X_MIN          = 10'd16,
  parameter logic [9:0]  X_MAX          = 10'd623,
  parameter logic [9:0]  Y_START        = 10'd0,
  parameter logic [9:0]  Y_FLOOR        = 10'd479,
  parameter logic [9:0]  PARK_X         = 10'd0,
  parameter logic [9:0]  PARK_Y         = 10'd0,
  parameter int          SPAWN_DELAY    = 30,
  parameter int          EXPLODE_FRAMES = 8,
  parameter logic [9:0]  STEP_INIT      = 10'd2,
  parameter logic [9:0]  STEP_MAX       = 10'd8,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic       enable,
  output logic [9:0] bombX,
  output logic [9:0] bombY,
  output logic       bomb_active,
  output logic       exploding,
  output logic [7:0] drop_count
);

  localparam int CNT_MAX = (SPAWN_DELAY > EXPLODE_FRAMES) ? SPAWN_DELAY : EXPLODE_FRAMES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] WAIT_LAST    = CNT_W'(SPAWN_DELAY - 1);
  localparam logic [CNT_W-1:0] EXPLODE_LAST = CNT_W'(EXPLODE_FRAMES - 1);

  // Elaboration-time guards on parameter combinations the FSM cannot honour.
  if (SPAWN_DELAY < 1) begin : g_bad_spawn_delay
    $error("bomb_dropper: SPAWN_DELAY must be at least 1");
  end
  if (EXPLODE_FRAMES < 1) begin : g_bad_explode_frames
    $error("bomb_dropper: EXPLODE_FRAMES must be at least 1");
  end
  if (LFSR_SEED == 16'h0000) begin : g_bad_seed
    $error("bomb_dropper: LFSR_SEED must be nonzero");
  end
  if (STEP_MAX < STEP_INIT) begin : g_bad_step
    $error("bomb_dropper: STEP_MAX must not be below STEP_INIT");
  end

  typedef enum logic [1:0] {
    S_WAIT    = 2'd0,
    S_FALL    = 2'd1,
    S_EXPLODE = 2'd2
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [15:0]      lfsr_q;
  logic [9:0]       step_q;
  logic [9:0]       x_q;
  logic [9:0]       bomb_x_q;
  logic [9:0]       bomb_y_q;
  logic             active_q;
  logic             exploding_q;
  logic [7:0]       drops_q;

  logic [15:0] lfsr_d;
  logic [9:0]  spawn_x_d;
  logic [10:0] fall_sum;
  logic        landed;
  logic [7:0]  drops_d;
  logic [9:0]  step_d;

  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

    if (lfsr_q[9:0] < X_MIN) begin
      spawn_x_d = X_MIN;
    end else if (lfsr_q[9:0] > X_MAX) begin
      spawn_x_d = X_MAX;
    end else begin
      spawn_x_d = lfsr_q[9:0];
    end

    // Widened by one bit so a large step near the floor cannot wrap past it.
    fall_sum = {1'b0, bomb_y_q} + {1'b0, step_q};
    landed   = (fall_sum >= {1'b0, Y_FLOOR});

    drops_d = (drops_q == 8'hFF) ? drops_q : drops_q + 8'd1;

`ifdef BOMB_SPEEDUP_EN
    if ((drops_d[2:0] == 3'b000) && (drops_d != drops_q) && (step_q < STEP_MAX)) begin
      step_d = step_q + 10'd1;
    end else begin
      step_d = step_q;
    end
`else
    step_d = step_q;
`endif
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state_q     <= S_WAIT;
      cnt_q       <= '0;
      lfsr_q      <= LFSR_SEED;
      step_q      <= STEP_INIT;
      x_q         <= X_MIN;
      bomb_x_q    <= PARK_X;
      bomb_y_q    <= PARK_Y;
      active_q    <= 1'b0;
      exploding_q <= 1'b0;
      drops_q     <= 8'd0;
    end else if (enable) begin
      lfsr_q <= lfsr_d;
      case (state_q)
        S_WAIT: begin
          if (cnt_q == WAIT_LAST) begin
            cnt_q    <= '0;
            x_q      <= spawn_x_d;
            bomb_x_q <= spawn_x_d;
            bomb_y_q <= Y_START;
            active_q <= 1'b1;
            state_q  <= S_FALL;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_FALL: begin
          bomb_x_q <= x_q;
          if (landed) begin
            bomb_y_q    <= Y_FLOOR;
            drops_q     <= drops_d;
            step_q      <= step_d;
            cnt_q       <= '0;
            exploding_q <= 1'b1;
            state_q     <= S_EXPLODE;
          end else begin
            bomb_y_q <= fall_sum[9:0];
          end
        end
        S_EXPLODE: begin
          if (cnt_q == EXPLODE_LAST) begin
            cnt_q       <= '0;
            bomb_x_q    <= PARK_X;
            bomb_y_q    <= PARK_Y;
            active_q    <= 1'b0;
            exploding_q <= 1'b0;
            state_q     <= S_WAIT;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          cnt_q   <= '0;
          state_q <= S_WAIT;
        end
      endcase
    end
  end

  assign bombX       = bomb_x_q;
  assign bombY       = bomb_y_q;
  assign bomb_active = active_q;
  assign exploding   = exploding_q;
  assign drop_count  = drops_q;

endmodule

// File: tb/tb_bomb_dropper.sv
// Randomized bench for bomb_dropper: a timeline model (frames since cycle start) predicts every output.
// Honours BOMB_SPEEDUP_EN when the same define is given to the build.
module tb_bomb_dropper;

  localparam int SD        = 1;
  localparam int EF        = 8;
  localparam int X_MIN     = 16;
  localparam int X_MAX     = 623;
  localparam int Y_START   = 0;
  localparam int Y_FLOOR   = 479;
  localparam int PARK_X    = 0;
  localparam int PARK_Y    = 0;
  localparam int STEP_INIT = 2;
  localparam int STEP_MAX  = 8;
  localparam logic [15:0] SEED = 16'hACE1;

  logic       frame_clk = 1'b0;
  logic       Reset;
  logic       enable;
  logic [9:0] bombX;
  logic [9:0] bombY;
  logic       bomb_active;
  logic       exploding;
  logic [7:0] drop_count;

  int checks   = 0;
  int failures = 0;

  bomb_dropper #(
    .X_MIN(10'(X_MIN)), .X_MAX(10'(X_MAX)), .Y_START(10'(Y_START)), .Y_FLOOR(10'(Y_FLOOR)),
    .PARK_X(10'(PARK_X)), .PARK_Y(10'(PARK_Y)), .SPAWN_DELAY(SD), .EXPLODE_FRAMES(EF),
    .STEP_INIT(10'(STEP_INIT)), .STEP_MAX(10'(STEP_MAX)), .LFSR_SEED(SEED)
  ) dut (
    .frame_clk(frame_clk), .Reset(Reset), .enable(enable),
    .bombX(bombX), .bombY(bombY), .bomb_active(bomb_active),
    .exploding(exploding), .drop_count(drop_count)
  );

  always #5 frame_clk = ~frame_clk;

  // Model: t counts enabled frames since the current wait-fall-explode cycle began.
  int          t;
  logic [15:0] m_lfsr;
  int          m_step, m_len, m_sx, m_drops, landings;
  int          m_x, m_y, m_act, m_exp;

  function automatic logic [15:0] galois(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic int clampx(input int c);
    if (c < X_MIN) return X_MIN;
    if (c > X_MAX) return X_MAX;
    return c;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic park();
    m_x = PARK_X; m_y = PARK_Y; m_act = 0; m_exp = 0;
  endtask

  task automatic model_edge(input bit rst, input bit en);
    logic [15:0] pre;
    int k;
    if (rst) begin
      t = 0; m_lfsr = SEED; m_step = STEP_INIT; m_drops = 0; landings = 0;
      park();
      return;
    end
    if (!en) return;
    pre    = m_lfsr;
    m_lfsr = galois(m_lfsr);
    t++;
    if (t == SD) begin
      m_sx  = clampx(int'(pre[9:0]));
      m_len = (Y_FLOOR - Y_START + m_step - 1) / m_step;
      m_x = m_sx; m_y = Y_START; m_act = 1; m_exp = 0;
    end else if (t > SD) begin
      k = t - SD;
      if (k < m_len) begin
        m_y = Y_START + k * m_step;
      end else if (k == m_len) begin
        m_y = Y_FLOOR; m_exp = 1;
        landings++;
        if (m_drops < 255) begin
          m_drops++;
`ifdef BOMB_SPEEDUP_EN
          if (m_drops % 8 == 0 && m_step < STEP_MAX) m_step++;
`endif
        end
        $display("landing %0d x=%0d step=%0d drops=%0d", landings, m_sx, m_step, m_drops);
`ifdef BOMB_SPEEDUP_EN
        if (landings == 8) check("speedup_step_at_8", m_step, 3);
        if (landings >= 48) check("speedup_step_cap", m_step, 8);
`endif
      end else if (k == m_len + EF) begin
        park();
        t = 0;
      end
    end
  endtask

  task automatic cycle(input bit rst, input bit en);
    Reset  = rst;
    enable = en;
    @(posedge frame_clk);
    #1;
    model_edge(rst, en);
    check("bombX", int'(bombX), m_x);
    check("bombY", int'(bombY), m_y);
    check("bomb_active", int'(bomb_active), m_act);
    check("exploding", int'(exploding), m_exp);
    check("drop_count", int'(drop_count), m_drops);
  endtask

  initial begin
    int n;
    Reset = 1'b1; enable = 1'b0;
    cycle(1, 0);
    cycle(1, 1);
    check("reset_bombX", int'(bombX), 0);
    check("reset_active", int'(bomb_active), 0);
    check("reset_drops", int'(drop_count), 0);

    // First spawn right after reset release.
    cycle(0, 1);
    check("spawn_x_225", int'(bombX), 225);
    check("spawn_y_0", int'(bombY), 0);
    check("spawn_active", int'(bomb_active), 1);
    check("model_lfsr_e270", int'(m_lfsr), 16'hE270);

    repeat (239) cycle(0, 1);
    check("fall_y_478", int'(bombY), 478);
    check("fall_not_exploding", int'(exploding), 0);
    cycle(0, 1);
    check("land_y_479", int'(bombY), 479);
    check("land_exploding", int'(exploding), 1);
    check("land_drops_1", int'(drop_count), 1);

    repeat (7) cycle(0, 1);
    check("explode_8th_frame", int'(exploding), 1);
    cycle(0, 1);
    check("explode_done", int'(exploding), 0);
    check("park_active", int'(bomb_active), 0);
    check("park_x", int'(bombX), 0);
    check("park_y", int'(bombY), 0);
    cycle(0, 1);
    check("respawn_active", int'(bomb_active), 1);

    // Freeze mid-fall at bombY=100.
    repeat (50) cycle(0, 1);
    check("freeze_pre_y", int'(bombY), 100);
    repeat (10) cycle(0, 0);
    check("freeze_hold_y", int'(bombY), 100);
    cycle(0, 1);
    check("freeze_resume_y", int'(bombY), 102);

    // Reset while exploding with three drops recorded.
    n = 0;
    while (!(m_drops == 3 && m_exp == 1) && n < 2000) begin
      cycle(0, 1);
      n++;
    end
    check("reach_drop3", int'(drop_count), 3);
    check("reach_exploding", int'(exploding), 1);
    cycle(1, 1);
    check("midreset_drops", int'(drop_count), 0);
    check("midreset_active", int'(bomb_active), 0);
    check("midreset_x", int'(bombX), 0);

    // Random enable gaps and occasional resets.
    repeat (4000) cycle($urandom_range(0, 499) == 0, $urandom_range(0, 7) != 0);

    // Long run to saturation.
    cycle(1, 1);
    n = 0;
    while (landings < 260 && n < 80000) begin
      cycle(0, $urandom_range(0, 15) != 0);
      n++;
    end
    check("saturation_landings", landings, 260);
    check("saturation_drops", int'(drop_count), 255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bomb_dropper.md
Name: bomb_dropper

Overview:
- Upstream stage of the hit/lives counter. It generates the falling bomb's screen position (bombX, bombY) once per frame.
- Each bomb spawns at a pseudo-random X, falls at a fixed per-frame step, and explodes for a few frames at the floor. It then waits before respawning.
- The hit counter consumes bombX/bombY directly. drop_count and exploding go to score and sprite logic.

Parameters:
- X_MIN, 10'd16, leftmost legal spawn X.
- X_MAX, 10'd623, rightmost legal spawn X.
- Y_START, 10'd0, spawn Y.
- Y_FLOOR, 10'd479, landing Y.
- PARK_X, 10'd0, bombX while no bomb is on screen.
- PARK_Y, 10'd0, bombY while no bomb is on screen.
- SPAWN_DELAY, 30, frames spent in WAIT (must be ≥1).
- EXPLODE_FRAMES, 8, frames spent in EXPLODE (must be ≥1).
- STEP_INIT, 10'd2, fall step in pixels per frame.
- STEP_MAX, 10'd8, step ceiling (used only with the optional feature).
- LFSR_SEED, 16'hACE1, LFSR reset value (nonzero).

Ports:
- frame_clk  in  1  frame clock; all state updates on its rising edge.
- Reset  in  1  synchronous, active-high reset.
- enable  in  1  game running; low freezes all state.
- bombX  out  10  bomb X position.
- bombY  out  10  bomb Y position.
- bomb_active  out  1  bomb visible (FALL or EXPLODE).
- exploding  out  1  high in EXPLODE only.
- drop_count  out  8  bombs landed, saturating at 255.

Behaviour:
- Clocking: one clock, frame_clk. Reset is synchronous and active-high, sampled on the frame_clk rising edge. Reset has priority over enable.
- Reset values:
  - state = WAIT, frame counter = 0, lfsr = LFSR_SEED, step = STEP_INIT.
  - latched X = X_MIN.
  - bombX = PARK_X, bombY = PARK_Y.
  - bomb_active = 0, exploding = 0, drop_count = 0.
- LFSR: 16-bit Galois, right shift, taps 16'hB400. Next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0). It advances every enabled frame, in every state.
- Spawn X: candidate = lfsr[9:0] sampled before the advance. If candidate < X_MIN use X_MIN; if candidate > X_MAX use X_MAX; otherwise use candidate.
- enable = 0: state, counter, lfsr, step, position and drop_count all hold. Outputs remain stable.
- WAIT:
  - bomb_active = 0; bombX/bombY = PARK_X/PARK_Y.
  - counter increments each frame.
  - When counter == SPAWN_DELAY-1: clear counter, latch spawn X, set bombY = Y_START, go to FALL.
- FALL:
  - bomb_active = 1; bombX = latched X.
  - If bombY + step >= Y_FLOOR (11-bit compare, no wrap): bombY = Y_FLOOR, drop_count += 1 (saturating at 255), counter = 0, go to EXPLODE.
  - Otherwise: bombY = bombY + step.
- EXPLODE:
  - bomb_active = 1, exploding = 1; position holds at (latched X, Y_FLOOR).
  - When counter == EXPLODE_FRAMES-1: clear counter, go to WAIT. On the transition, bombX/bombY move to park.
- All outputs are registered. A value changes on the frame edge that performs the transition, with no extra latency.
- Reset during FALL or EXPLODE returns to WAIT on that same edge. No partial drop is counted.

Optional Feature:
- Macro: BOMB_SPEEDUP_EN.
- Defined: on each EXPLODE entry where the new drop_count[2:0] == 3'b000 (every 8 landings), step = min(step + 1, STEP_MAX). The new step takes effect from the next FALL.
- Not defined: step is constant at STEP_INIT and STEP_MAX is unused.

Test Plan:
- Reset with SPAWN_DELAY=1, enable=1 → first edge after Reset deasserts: FALL, bombX=225 (0xACE1[9:0]), bombY=0, bomb_active=1, lfsr=0xE270.
- Fall with STEP_INIT=2, Y_FLOOR=479 → bombY=478 after 239 FALL frames. The 240th frame gives bombY=479, exploding=1, drop_count=1.
- Explode with EXPLODE_FRAMES=8 → exploding high for exactly 8 frames, then bomb_active=0 and bombX/bombY=0/0. FALL resumes after SPAWN_DELAY frames.
- Spawn clamp: force lfsr[9:0]=10'd5 → bombX=16; force lfsr[9:0]=10'd1000 → bombX=623.
- Freeze: enable=0 for 10 frames mid-FALL at bombY=100 → bombY, lfsr and state unchanged. After enable returns to 1, bombY=102 on the next edge.
- Reset mid-operation: Reset in EXPLODE with drop_count=3 → next edge: WAIT, drop_count=0, park position.
- With BOMB_SPEEDUP_EN: 8th landing → step=3, and the next fall advances 3 pixels per frame. After 48 landings → step=8 and it stays 8.
- Saturation: 256 landings → drop_count=255.
